// File: rtl/norm2_pkg.sv
// Shared constants and state encoding for the norm2 sum-of-squares / dot-product engine.
package norm2_pkg;

    localparam logic MODE_SQ  = 1'b0;
    localparam logic MODE_DOT = 1'b1;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

endpackage

// File: rtl/norm2_bank.sv
// Single-port operand RAM with a registered read address (one-cycle read latency).
module norm2_bank #(
    parameter int DEPTH  = 1000,
    parameter int DATA_W = 27,
    parameter int IDX_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  addr_q;

    // A write cycle leaves the read address untouched, so the previous read result stays visible.
    always_ff @(posedge clk) begin
        if (en && we) begin
            if (addr <= LAST) begin
                mem[addr] <= wdata;
            end
        end else if (en) begin
            addr_q <= addr;
        end
    end

    assign rdata = (addr_q <= LAST) ? mem[addr_q] : '0;

endmodule

// File: rtl/norm2_engine.sv
// Two-bank multiply-accumulate engine: streams an index range through a 3-stage pipeline
// and returns the sum of A[i]^2 or A[i]*B[i] added to a seed, with a done pulse.
module norm2_engine
    import norm2_pkg::*;
#(
    parameter int DEPTH  = 1000,
    parameter int DATA_W = 27,
    parameter int ACC_W  = 64,
    parameter int IDX_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [IDX_W-1:0]  init_i,
    input  logic [IDX_W-1:0]  count,
    input  logic [ACC_W-1:0]  init_acc,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  result,
    input  logic              ctrl_en,
    input  logic              ctrl_sel,
    input  logic              ctrl_we,
    input  logic [IDX_W-1:0]  ctrl_addr,
    input  logic [DATA_W-1:0] ctrl_wdata,
    output logic [DATA_W-1:0] ctrl_rdata,
    output logic              ctrl_ready
);

    state_t                    state;
    logic                      mode_q;
    logic [IDX_W-1:0]          next_addr;
    logic [IDX_W-1:0]          remaining;
    logic                      drain_cnt;
    logic [ACC_W-1:0]          acc;
    logic [ACC_W-1:0]          acc_next;

    logic [IDX_W-1:0]          p0_addr;
    logic                      v0, v1, v2;
    logic signed [2*DATA_W-1:0] p2;

    logic                      host_acc, host_rd;
    logic                      a_en, b_en, bank_we;
    logic [IDX_W-1:0]          bank_addr;
    logic [DATA_W-1:0]         rdata_a, rdata_b;
    logic                      rd_pend, rd_sel_q;
    logic [DATA_W-1:0]         rd_hold, rd_live;

    assign ctrl_ready = !busy;
    assign host_acc   = ctrl_en && !busy;
    assign host_rd    = host_acc && !ctrl_we;

    // The host owns both banks while idle; during a run the P0 address drives them.
    assign bank_we   = host_acc && ctrl_we;
    assign bank_addr = busy ? p0_addr : ctrl_addr;
    assign a_en      = (host_acc && ctrl_sel == SEL_A) || (busy && v0);
    assign b_en      = (host_acc && ctrl_sel == SEL_B) || (busy && v0 && mode_q == MODE_DOT);

    norm2_bank #(.DEPTH(DEPTH), .DATA_W(DATA_W), .IDX_W(IDX_W)) bank_a (
        .clk   (clk),
        .en    (a_en),
        .we    (bank_we),
        .addr  (bank_addr),
        .wdata (ctrl_wdata),
        .rdata (rdata_a)
    );

    norm2_bank #(.DEPTH(DEPTH), .DATA_W(DATA_W), .IDX_W(IDX_W)) bank_b (
        .clk   (clk),
        .en    (b_en),
        .we    (bank_we),
        .addr  (bank_addr),
        .wdata (ctrl_wdata),
        .rdata (rdata_b)
    );

    assign acc_next = v2 ? acc + ACC_W'(p2) : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            acc       <= '0;
            mode_q    <= MODE_SQ;
            next_addr <= '0;
            remaining <= '0;
            drain_cnt <= 1'b0;
            p0_addr   <= '0;
            v0        <= 1'b0;
        end else begin
            done <= 1'b0;
            v0   <= 1'b0;
            acc  <= acc_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        mode_q    <= mode;
                        acc       <= init_acc;
                        next_addr <= init_i;
                        remaining <= (init_i >= count) ? '0 : count - init_i;
                    end
                end
                RUN: begin
                    if (remaining != '0) begin
                        p0_addr   <= next_addr;
                        v0        <= 1'b1;
                        next_addr <= next_addr + IDX_W'(1);
                        remaining <= remaining - IDX_W'(1);
                    end else begin
                        state     <= DRAIN;
                        drain_cnt <= 1'b0;
                    end
                end
                DRAIN: begin
                    // Second drain cycle coincides with the last product landing in the accumulator.
                    if (drain_cnt) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= acc_next;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            p2 <= '0;
        end else begin
            v1 <= v0;
            v2 <= v1;
            if (v1) begin
                p2 <= $signed(rdata_a) * $signed((mode_q == MODE_DOT) ? rdata_b : rdata_a);
            end
        end
    end

    // Host read data is captured once so later engine reads cannot disturb it.
    assign rd_live = (rd_sel_q == SEL_B) ? rdata_b : rdata_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend  <= 1'b0;
            rd_sel_q <= SEL_A;
            rd_hold  <= '0;
        end else begin
            rd_pend <= host_rd;
            if (host_rd) begin
                rd_sel_q <= ctrl_sel;
            end
            if (rd_pend) begin
                rd_hold <= rd_live;
            end
        end
    end

    assign ctrl_rdata = busy ? '0 : (rd_pend ? rd_live : rd_hold);

endmodule

// File: tb/tb_norm2_engine.sv
// Self-checking bench for norm2_engine: a cycle-level reference model compared every cycle,
// plus directed runs with hand-computed results, latencies and host-port behaviour.
module tb_norm2_engine;
    import norm2_pkg::*;

    localparam int DEPTH  = 1000;
    localparam int DATA_W = 27;
    localparam int ACC_W  = 64;
    localparam int IDX_W  = $clog2(DEPTH + 1);

    logic              clk        = 1'b0;
    logic              rst_n      = 1'b0;
    logic              start      = 1'b0;
    logic              mode       = 1'b0;
    logic [IDX_W-1:0]  init_i     = '0;
    logic [IDX_W-1:0]  count      = '0;
    logic [ACC_W-1:0]  init_acc   = '0;
    logic              busy, done;
    logic [ACC_W-1:0]  result;
    logic              ctrl_en    = 1'b0;
    logic              ctrl_sel   = 1'b0;
    logic              ctrl_we    = 1'b0;
    logic [IDX_W-1:0]  ctrl_addr  = '0;
    logic [DATA_W-1:0] ctrl_wdata = '0;
    logic [DATA_W-1:0] ctrl_rdata;
    logic              ctrl_ready;

    int n_compared   = 0;
    int n_mismatched = 0;

    longint            ma [DEPTH];
    longint            mb [DEPTH];
    bit                m_busy    = 1'b0;
    bit                m_done    = 1'b0;
    longint            m_result  = 0;
    longint            m_pending = 0;
    logic [DATA_W-1:0] m_rd      = '0;
    int                m_left    = 0;

    norm2_engine #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ACC_W(ACC_W), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode       (mode),
        .init_i     (init_i),
        .count      (count),
        .init_acc   (init_acc),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .ctrl_en    (ctrl_en),
        .ctrl_sel   (ctrl_sel),
        .ctrl_we    (ctrl_we),
        .ctrl_addr  (ctrl_addr),
        .ctrl_wdata (ctrl_wdata),
        .ctrl_rdata (ctrl_rdata),
        .ctrl_ready (ctrl_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: a run is a result computed up front plus a countdown of n+3 edges.
    always @(posedge clk or negedge rst_n) begin : model
        longint s;
        int     n;
        if (!rst_n) begin
            m_busy   = 1'b0;
            m_done   = 1'b0;
            m_result = 0;
            m_rd     = '0;
            m_left   = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy   = 1'b0;
                    m_done   = 1'b1;
                    m_result = m_pending;
                end
            end else begin
                if (ctrl_en) begin
                    if (ctrl_we) begin
                        if (int'(ctrl_addr) < DEPTH) begin
                            if (ctrl_sel == SEL_B) mb[ctrl_addr] = longint'($signed(ctrl_wdata));
                            else                   ma[ctrl_addr] = longint'($signed(ctrl_wdata));
                        end
                    end else begin
                        if (int'(ctrl_addr) < DEPTH)
                            m_rd = (ctrl_sel == SEL_B) ? DATA_W'(mb[ctrl_addr]) : DATA_W'(ma[ctrl_addr]);
                        else
                            m_rd = '0;
                    end
                end
                if (start) begin
                    n = (init_i >= count) ? 0 : int'(count) - int'(init_i);
                    s = longint'(init_acc);
                    for (int i = int'(init_i); i < int'(init_i) + n; i++) begin
                        s += (mode == MODE_DOT) ? ma[i] * mb[i] : ma[i] * ma[i];
                    end
                    m_pending = s;
                    m_left    = n + 3;
                    m_busy    = 1'b1;
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic compare_cycle();
        check_output("busy",       64'(busy),       64'(m_busy));
        check_output("done",       64'(done),       64'(m_done));
        check_output("result",     result,          64'(m_result));
        check_output("ctrl_ready", 64'(ctrl_ready), 64'(!m_busy));
        check_output("ctrl_rdata", 64'(ctrl_rdata), m_busy ? 64'd0 : 64'(m_rd));
    endtask

    task automatic tick();
        @(negedge clk);
        compare_cycle();
    endtask

    task automatic apply_stimulus(input logic en, input logic sel, input logic we,
                                  input int addr, input logic [DATA_W-1:0] wdata);
        ctrl_en    = en;
        ctrl_sel   = sel;
        ctrl_we    = we;
        ctrl_addr  = IDX_W'(addr);
        ctrl_wdata = wdata;
    endtask

    task automatic write_word(input logic sel, input int addr, input int value);
        apply_stimulus(1'b1, sel, 1'b1, addr, DATA_W'(value));
        tick();
        apply_stimulus(1'b0, SEL_A, 1'b0, 0, '0);
    endtask

    task automatic read_word(input string name, input logic sel, input int addr, input logic [DATA_W-1:0] expected);
        apply_stimulus(1'b1, sel, 1'b0, addr, '0);
        tick();
        check_output(name, 64'(ctrl_rdata), 64'(expected));
        apply_stimulus(1'b0, SEL_A, 1'b0, 0, '0);
    endtask

    task automatic run_job(input string name, input logic m, input int ii, input int cc,
                           input logic [63:0] acc0, input int exp_off, input logic [63:0] exp_res);
        int cyc;
        int busy_cnt;
        mode     = m;
        init_i   = IDX_W'(ii);
        count    = IDX_W'(cc);
        init_acc = acc0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        cyc      = 1;
        busy_cnt = 0;
        while (!done && cyc < 3000) begin
            if (busy) busy_cnt++;
            tick();
            cyc++;
        end
        check_output({name, "_done_seen"}, 64'(done), 64'd1);
        check_output({name, "_latency"}, 64'(cyc - 1), 64'(exp_off));
        check_output({name, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_off));
        check_output({name, "_result"}, result, exp_res);
    endtask

    initial begin : stimulus
        int a_vals [4] = '{1, -2, 3, -4};
        int cyc;

        tick();
        tick();
        check_output("reset_busy",   64'(busy),       64'd0);
        check_output("reset_done",   64'(done),       64'd0);
        check_output("reset_result", result,          64'd0);
        check_output("reset_ready",  64'(ctrl_ready), 64'd1);
        check_output("reset_rdata",  64'(ctrl_rdata), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) write_word(SEL_A, i, a_vals[i]);
        read_word("read_a1", SEL_A, 1, 27'h7FFFFFE);
        run_job("sq4", MODE_SQ, 0, 4, 64'd0, 7, 64'd30);

        for (int i = 0; i < 3; i++) write_word(SEL_A, i, i + 1);
        write_word(SEL_B, 0, 4);
        write_word(SEL_B, 1, -5);
        write_word(SEL_B, 2, 6);
        run_job("dot3", MODE_DOT, 0, 3, 64'd100, 6, 64'd112);
        run_job("empty_eq", MODE_SQ, 5, 5, 64'd7, 3, 64'd7);
        run_job("empty_gt", MODE_SQ, 9, 5, 64'd7, 3, 64'd7);

        write_word(SEL_A, 0, 1);
        run_job("wrap", MODE_SQ, 0, 1, 64'h7FFF_FFFF_FFFF_FFFF, 4, 64'h8000_0000_0000_0000);
        write_word(SEL_A, 0, -(1 << 26));
        run_job("minsq", MODE_SQ, 0, 1, 64'd0, 4, 64'h0010_0000_0000_0000);

        read_word("read_b1", SEL_B, 1, 27'h7FFFFFB);
        read_word("read_oob", SEL_A, 1000, '0);

        for (int i = 0; i < 10; i++) write_word(SEL_A, i, i + 1);
        mode     = MODE_SQ;
        init_i   = IDX_W'(0);
        count    = IDX_W'(10);
        init_acc = 64'd0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        apply_stimulus(1'b1, SEL_A, 1'b1, 0, DATA_W'(99));
        start = 1'b1;
        mode  = MODE_DOT;
        tick();
        start = 1'b0;
        check_output("busy_rdata_wr", 64'(ctrl_rdata), 64'd0);
        apply_stimulus(1'b1, SEL_A, 1'b0, 1, '0);
        tick();
        check_output("busy_rdata_rd", 64'(ctrl_rdata), 64'd0);
        apply_stimulus(1'b0, SEL_A, 1'b0, 0, '0);
        cyc = 0;
        while (!done && cyc < 100) begin
            tick();
            cyc++;
        end
        check_output("busy_run_done", 64'(done), 64'd1);
        check_output("busy_run_result", result, 64'd385);
        tick();
        read_word("a0_kept", SEL_A, 0, 27'd1);

        mode     = MODE_SQ;
        init_i   = IDX_W'(0);
        count    = IDX_W'(10);
        init_acc = 64'd0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_output("midrun_busy",   64'(busy),   64'd0);
        check_output("midrun_done",   64'(done),   64'd0);
        check_output("midrun_result", result,      64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        run_job("after_reset", MODE_SQ, 0, 10, 64'd0, 13, 64'd385);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/norm2_engine.md
# norm2_engine

Parametrised sum-of-squares / dot-product engine, successor to the fixed 1000 × 27-bit norm2 kernel. Holds two on-chip operand banks (A, B) loaded through a host port. On `start` it streams a runtime-selected index range through a fully pipelined multiply-accumulate at one element per cycle, replacing the old 8-state loop. It sits beside the host/control logic and returns a single accumulated result with a `done` pulse.

## Interface
- `DEPTH`, 1000, words per bank
- `DATA_W`, 27, signed element width
- `ACC_W`, 64, signed accumulator/result width; must be ≥ 2·DATA_W
- `IDX_W`, $clog2(DEPTH+1), index/count width
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request; sampled only while idle
- `mode`  in  1  0 = Σ A[i]², 1 = Σ A[i]·B[i]; sampled with `start`
- `init_i`  in  IDX_W  first index
- `count`  in  IDX_W  end index (exclusive), ≤ DEPTH
- `init_acc`  in  ACC_W  signed accumulator seed
- `busy`  out  1  high from the edge that accepts `start` until `done`
- `done`  out  1  one-cycle pulse, result valid
- `result`  out  ACC_W  held until the next accepted `start`
- `ctrl_en`  in  1  host access request
- `ctrl_sel`  in  1  0 = bank A, 1 = bank B
- `ctrl_we`  in  1  write strobe
- `ctrl_addr`  in  IDX_W  word address
- `ctrl_wdata`  in  DATA_W  write data
- `ctrl_rdata`  out  DATA_W  read data, one cycle after the request
- `ctrl_ready`  out  1  = !busy; host accesses are accepted only when high

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE → RUN on `start`. The engine latches `mode`, `init_acc`, and n = count − init_i. If init_i ≥ count, n = 0.
- RUN: issues address init_i + k for k = 0..n−1, one per cycle, to both banks. It enters DRAIN after the last issue. For n = 0 it goes straight to DRAIN.
- DRAIN: lasts 2 cycles while the read and multiply stages empty. Then `done` = 1, `result` = acc, and the FSM returns to IDLE.
- Pipeline has three stages:
  - P0: address register.
  - P1: bank read data, 1-cycle synchronous read.
  - P2: product register.
  - Accumulate: acc += sign-extended product. A valid bit travels with each stage.
- Arithmetic:
  - Operands are signed DATA_W.
  - Product is signed 2·DATA_W, sign-extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W; there is no saturation.
- In mode 0 bank B is not read.
- Host port:
  - While `ctrl_ready` = 1 and `ctrl_en` = 1, the selected bank is written when `ctrl_we` = 1, otherwise it is read.
  - While busy, `ctrl_en` is ignored: no write takes place and `ctrl_rdata` = 0.
- A `start` arriving while busy is dropped. A `start` in the same cycle as an accepted host access is also accepted; the host access completes first, so it uses the pre-run bank contents.
- A write to address ≥ DEPTH is ignored. A read from address ≥ DEPTH returns 0.

## Timing
- Reset (rst_n low, asynchronous) forces:
  - FSM = IDLE, all valid bits = 0.
  - `busy` = 0, `done` = 0, `result` = 0, `ctrl_rdata` = 0, `ctrl_ready` = 1.
  - Bank contents are not reset.
- Reset mid-run: the run is abandoned immediately, no `done` is produced, and the engine is idle after release.
- Edge E0 accepts `start`.
  - `busy` is high from E0.
  - `done` and the final `result` update at edge E0 + n + 3.
  - `busy` falls at that same edge.
- Throughput: 1 element per cycle. Back-to-back runs are possible: `start` is accepted in the cycle `done` is high, which gives a gap of one cycle.
- `ctrl_rdata` is valid in the cycle after a read request and then holds until the next read.

## Structure
- `norm2_pkg` contains:
  - mode constants `MODE_SQ` = 0 and `MODE_DOT` = 1.
  - state enum {IDLE, RUN, DRAIN}.
  - bank-select constants.
- Sub-module `norm2_bank`, instantiated twice (A and B):
  - single-port RAM, DEPTH × DATA_W.
  - registered read address, 1-cycle read latency.
  - write has priority over read on the same cycle.
- The port mux between host and engine sits in `norm2_engine`.

## Test plan
- Mode 0: A[0..3] = {1, −2, 3, −4}, init_i = 0, count = 4, init_acc = 0 → `done` at E0+7, `result` = 30, `busy` high for 7 cycles.
- Mode 1: A[0..2] = {1, 2, 3}, B[0..2] = {4, −5, 6}, init_acc = 100 → `result` = 112.
- Empty range: init_i = 5, count = 5, init_acc = 7 → `done` at E0+3, `result` = 7. Repeat with init_i = 9, count = 5 → same result.
- Wrap: DATA_W = 27, A[0] = 1, init_acc = 2^63 − 1, mode 0 → `result` = −2^63. Also A[0] = −2^26 squared → 2^52 exactly.
- Busy interactions: while busy, issue host write A[0] = 99 and a second `start` → write dropped, `start` dropped, `ctrl_rdata` = 0, and a later read of A[0] returns the old value.
- Reset: assert rst_n low at E0+2 of a 10-element run → `busy`, `done`, `result` = 0 immediately. After release a new run on the same data gives the correct sum (banks retained).
